fifo_burst_rd: RTL and testbench

- Downstream consumer of the synchronous FIFO.
- Watches the FIFO fill level. When it reaches a threshold, it reads exactly one burst of BURST_LEN words and presents them as a stream with valid/ready/last.
- Handles both FIFO read modes: SHOWAHEAD=0 (1-cycle read latency) and SHOWAHEAD=1 (data valid with rden).
- A 2-entry output buffer absorbs downstream backpressure with no data loss.

---
 rtl/fifo_burst_rd_pkg.sv | 15 +
 rtl/fifo_burst_rd_if.sv | 33 +++
 rtl/fifo_out_buf.sv | 55 +++++
 rtl/fifo_burst_rd.sv | 101 ++++++++++
 tb/tb_fifo_burst_rd.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_burst_rd_pkg.sv
// Shared types for the FIFO burst reader.
// State encoding and counter sizing.
package fifo_burst_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/fifo_burst_rd_if.sv
// FIFO read side and output stream of the burst reader.
// master = reader, slave = FIFO plus stream sink.
interface fifo_burst_rd_if #(
    parameter int DBITS = 16,
    parameter int ABITS = 10
);
    logic [ABITS-1:0] fifo_num;
    logic             fifo_rdempty;
    logic [DBITS-1:0] fifo_rd_data;
    logic             fifo_rden;
    logic [DBITS-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic             burst_active;
    logic             burst_done;

    modport master (
        input  fifo_num, fifo_rdempty,
        input  fifo_rd_data, m_axis_tready,
        output fifo_rden, m_axis_tdata,
        output m_axis_tvalid, m_axis_tlast,
        output burst_active, burst_done
    );

    modport slave (
        output fifo_num, fifo_rdempty,
        output fifo_rd_data, m_axis_tready,
        input  fifo_rden, m_axis_tdata,
        input  m_axis_tvalid, m_axis_tlast,
        input  burst_active, burst_done
    );
endinterface

// File: rtl/fifo_out_buf.sv
// Two-entry skid buffer between FIFO reads and the stream.
// d0 is always the head; d1 only holds the second word.
module fifo_out_buf #(
    parameter int DBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DBITS-1:0] push_data,
    input  logic             ready,
    output logic             valid,
    output logic [DBITS-1:0] data,
    output logic [1:0]       occ
);
    logic [DBITS-1:0] d0, d1;
    logic             pop;

    assign valid = occ != 2'd0;
    assign pop   = valid & ready;
    assign data  = d0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= 2'd0;
            d0  <= '0;
            d1  <= '0;
        end else begin
            unique case (1'b1)
                push && !pop: begin
                    if (occ == 2'd0) d0 <= push_data;
                    else             d1 <= push_data;
                    occ <= occ + 2'd1;
                end
                pop && !push: begin
                    d0  <= d1;
                    occ <= occ - 2'd1;
                end
                push && pop: begin
                    if (occ == 2'd1) begin
                        d0 <= push_data;
                    end else begin
                        d0 <= d1;
                        d1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(push && !pop && occ == 2'd2)
    );
endmodule

// File: rtl/fifo_burst_rd.sv
// Waits for the FIFO to reach a fill threshold, then streams
// exactly one burst of words out with valid/ready/last.
module fifo_burst_rd
    import fifo_burst_rd_pkg::*;
#(
    parameter int DBITS      = 16,
    parameter int ABITS      = 10,
    parameter int SHOWAHEAD  = 0,
    parameter int BURST_LEN  = 500,
    parameter int BURST_THRD = 512
) (
    input  logic            clk,
    input  logic            rst,
    fifo_burst_rd_if.master bus
);
    localparam int CW = cnt_width(BURST_LEN);
    localparam logic [ABITS-1:0] THRD = ABITS'(BURST_THRD);
    localparam logic [CW-1:0]    LEN  = CW'(BURST_LEN);
    localparam logic [CW-1:0]    LAST = CW'(BURST_LEN - 1);

    if (BURST_LEN < 1 || BURST_THRD < BURST_LEN ||
        BURST_THRD > (1 << ABITS) - 1) begin : g_bad_cfg
        $error("fifo_burst_rd: illegal BURST_LEN/BURST_THRD");
    end

    state_t        state, state_nx;
    logic [CW-1:0] rd_left, beat_cnt;
    logic [1:0]    occ;
    logic [2:0]    level;
    logic          inflight, pop, rden, push;
    logic          start, last_hs;

    assign pop     = bus.m_axis_tvalid & bus.m_axis_tready;
    // words held or on their way, after this cycle's pop leaves
    assign level   = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign rden    = (state == BURST) && (rd_left != '0) &&
                     !bus.fifo_rdempty && (level < 3'd2);
    assign start   = (state == IDLE) && (bus.fifo_num >= THRD);
    assign last_hs = pop & bus.m_axis_tlast;

    assign bus.fifo_rden    = rden;
    assign bus.m_axis_tlast = bus.m_axis_tvalid && (beat_cnt == LAST);
    assign bus.burst_active = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = BURST;
            BURST:   if (rden && rd_left == CW'(1)) state_nx = DRAIN;
            DRAIN:   if (last_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_left        <= '0;
            beat_cnt       <= '0;
            bus.burst_done <= 1'b0;
        end else begin
            bus.burst_done <= last_hs;
            if (start) begin
                rd_left  <= LEN;
                beat_cnt <= '0;
            end else begin
                if (rden)         rd_left  <= rd_left - CW'(1);
                if (last_hs)      beat_cnt <= '0;
                else if (pop)     beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

    if (SHOWAHEAD != 0) begin : g_showahead
        assign inflight = 1'b0;
        assign push     = rden;
    end else begin : g_latency
        always_ff @(posedge clk or posedge rst) begin
            if (rst) inflight <= 1'b0;
            else     inflight <= rden;
        end
        assign push = inflight;
    end

    fifo_out_buf #(
        .DBITS(DBITS)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(bus.fifo_rd_data),
        .ready    (bus.m_axis_tready),
        .valid    (bus.m_axis_tvalid),
        .data     (bus.m_axis_tdata),
        .occ      (occ)
    );
endmodule

// File: tb/tb_fifo_burst_rd.sv
// Bench for fifo_burst_rd: both read modes against a FIFO model
// holding words 1..N and a stream scoreboard.
module tb_fifo_burst_rd;
    localparam int BL = 500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_burst_rd_if #(.DBITS(16), .ABITS(10)) ifa ();
    fifo_burst_rd_if #(.DBITS(16), .ABITS(10)) ifb ();

    fifo_burst_rd #(.SHOWAHEAD(0)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    fifo_burst_rd #(.SHOWAHEAD(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // FIFO model: word k has value k; avail = words ever written
    int          avail_a = 0, avail_b = 0;
    int          ptr_a = 0, ptr_b = 0;
    int          rcnt_a = 0, rcnt_b = 0;
    logic [15:0] da = '0;
    logic        emp_err = 1'b0;
    logic        clr = 1'b1;
    logic        force_e = 1'b0;
    logic        tready = 1'b1;
    logic        sel = 1'b0;
    logic        no_rden = 1'b0;

    assign ifa.fifo_num      = 10'(avail_a - ptr_a);
    assign ifa.fifo_rdempty  = (avail_a == ptr_a) || force_e;
    assign ifa.fifo_rd_data  = da;
    assign ifa.m_axis_tready = tready;
    assign ifb.fifo_num      = 10'(avail_b - ptr_b);
    assign ifb.fifo_rdempty  = avail_b == ptr_b;
    assign ifb.fifo_rd_data  = 16'(ptr_b + 1);
    assign ifb.m_axis_tready = tready;

    always @(posedge clk) begin
        if (clr) begin
            ptr_a  <= 0;
            ptr_b  <= 0;
            rcnt_a <= 0;
            rcnt_b <= 0;
            da     <= '0;
        end else begin
            if (ifa.fifo_rden) begin
                if (ifa.fifo_rdempty) emp_err <= 1'b1;
                da     <= 16'(ptr_a + 1);
                ptr_a  <= ptr_a + 1;
                rcnt_a <= rcnt_a + 1;
            end
            if (ifb.fifo_rden) begin
                if (ifb.fifo_rdempty) emp_err <= 1'b1;
                ptr_b  <= ptr_b + 1;
                rcnt_b <= rcnt_b + 1;
            end
        end
    end

    logic        m_v, m_l, m_bd, m_ba, m_rden;
    logic [15:0] m_d;
    assign m_v    = sel ? ifb.m_axis_tvalid : ifa.m_axis_tvalid;
    assign m_l    = sel ? ifb.m_axis_tlast  : ifa.m_axis_tlast;
    assign m_d    = sel ? ifb.m_axis_tdata  : ifa.m_axis_tdata;
    assign m_bd   = sel ? ifb.burst_done    : ifa.burst_done;
    assign m_ba   = sel ? ifb.burst_active  : ifa.burst_active;
    assign m_rden = sel ? ifb.fifo_rden     : ifa.fifo_rden;

    int          cyc, beats, done_cnt, ba_cyc, v_cyc;
    int          hs_first, hs_last;
    logic        prev_v, prev_r, prev_l, prev_lhs, prev_ba;
    logic [15:0] prev_d;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic mreset();
        cyc = 0; beats = 0; done_cnt = 0;
        ba_cyc = -1; v_cyc = -1; hs_first = -1; hs_last = -1;
        prev_v = 0; prev_r = 0; prev_l = 0;
        prev_lhs = 0; prev_ba = 0; prev_d = '0;
    endtask

    // one sample per cycle, on the falling edge
    task automatic mon();
        cyc++;
        if (prev_v && !prev_r) begin
            chk("hold_valid", 32'(m_v), 1);
            chk("hold_data", 32'(m_d), 32'(prev_d));
            chk("hold_last", 32'(m_l), 32'(prev_l));
        end
        if (m_v) begin
            chk("data", 32'(m_d), 32'(beats % BL + 1));
            chk("last", 32'(m_l), 32'((beats % BL) == BL - 1));
            if (v_cyc < 0) v_cyc = cyc;
        end
        chk("done", 32'(m_bd), 32'(prev_lhs));
        if (no_rden) chk("rden_stall", 32'(m_rden), 0);
        if (m_ba && !prev_ba && ba_cyc < 0) ba_cyc = cyc;
        if (m_v && tready) begin
            if (hs_first < 0) hs_first = cyc;
            hs_last = cyc;
            beats++;
        end
        if (m_bd) done_cnt++;
        prev_lhs = m_v && tready && m_l;
        prev_v = m_v; prev_r = tready; prev_l = m_l;
        prev_d = m_d; prev_ba = m_ba;
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input int aa, input int ab,
                           input logic s);
        rst = 1; clr = 1; sel = s;
        force_e = 0; no_rden = 0; tready = 1;
        repeat (2) @(posedge clk);
        #1;
        avail_a = aa; avail_b = ab;
        clr = 0; mreset(); rst = 0;
    endtask

    // mode: 0 plain, 2 hold@100, 3 empty@250, 4 stop@200
    task automatic run_burst(input int budget, input bit rnd,
                             input int mode);
        int n = 0, hold = 0, stall = 0;
        bit held = 0, stalled = 0;
        while (done_cnt == 0 && n < budget) begin
            if (mode == 4 && beats == 200) break;
            if (mode == 2 && !held && beats == 100) begin
                held = 1; hold = 20;
            end
            if (mode == 3 && !stalled && rcnt_a == 250) begin
                stalled = 1; stall = 10;
            end
            no_rden = (hold > 0 && hold <= 18) || stall > 0;
            force_e = stall > 0;
            tready  = hold > 0 ? 1'b0 :
                      (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            if (hold > 0) hold--;
            if (stall > 0) stall--;
            step();
            n++;
        end
        no_rden = 0; force_e = 0; tready = 1;
        if (mode == 2) chk("hold_hit", 32'(held), 1);
        if (mode == 3) chk("stall_hit", 32'(stalled), 1);
        if (mode == 4) chk("mid_point", beats, 200);
        else           chk("burst_timeout", 32'(done_cnt != 0), 1);
    endtask

    task automatic post_checks(input int lat);
        repeat (4) step();
        chk("beats", beats, BL);
        chk("done_once", done_cnt, 1);
        chk("rden_cnt", sel ? rcnt_b : rcnt_a, BL);
        chk("idle_after", 32'(m_ba), 0);
        if (lat >= 0) begin
            chk("latency", v_cyc - ba_cyc, lat);
            chk("consecutive", hs_last - hs_first, BL - 1);
        end
    endtask

    initial begin
        mreset();
        avail_a = 600;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rden", 32'(ifa.fifo_rden), 0);
        chk("rst_tvalid", 32'(ifa.m_axis_tvalid), 0);
        chk("rst_tlast", 32'(ifa.m_axis_tlast), 0);
        chk("rst_active", 32'(ifa.burst_active), 0);
        chk("rst_done", 32'(ifa.burst_done), 0);
        clr = 0; rst = 0;
        step();
        chk("start_first_edge", 32'(ifa.burst_active), 1);
        run_burst(1000, 0, 0);
        post_checks(2);

        restart(511, 0, 1'b0);
        no_rden = 1;
        repeat (8) step();
        no_rden = 0;
        chk("below_thrd_active", 32'(m_ba), 0);
        chk("below_thrd_reads", rcnt_a, 0);
        avail_a = 1000;
        run_burst(1000, 0, 0);
        post_checks(2);

        restart(0, 511, 1'b1);
        no_rden = 1;
        repeat (8) step();
        no_rden = 0;
        chk("sa1_below_thrd", 32'(m_ba), 0);
        avail_b = 1000;
        run_burst(1000, 0, 0);
        post_checks(1);

        restart(1000, 0, 1'b0);
        run_burst(4000, 1, 2);
        post_checks(-1);

        restart(1000, 0, 1'b0);
        run_burst(1000, 0, 3);
        post_checks(-1);

        restart(1000, 0, 1'b0);
        run_burst(1000, 0, 4);
        rst = 1;
        #1;
        chk("async_rden", 32'(ifa.fifo_rden), 0);
        chk("async_tvalid", 32'(ifa.m_axis_tvalid), 0);
        chk("async_tlast", 32'(ifa.m_axis_tlast), 0);
        chk("async_active", 32'(ifa.burst_active), 0);
        chk("async_done", 32'(ifa.burst_done), 0);
        restart(1000, 0, 1'b0);
        run_burst(1000, 0, 0);
        post_checks(2);

        chk("never_read_empty", 32'(emp_err), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
